// File: rtl/pixel_diffusion.sv
// Streaming logistic-map substitution/diffusion stage with ciphertext chaining.
// Optional decrypt mode is compiled in with `define DIFFUSION_DECRYPT_EN.
module pixel_diffusion #(
   parameter int IMG_W  = 256,
   parameter int IMG_H  = 256,
   parameter int WARMUP = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] cfg_seed,
   input  logic [15:0] cfg_r,
   input  logic [7:0]  cfg_c0,
`ifdef DIFFUSION_DECRYPT_EN
   input  logic        cfg_decrypt,
`endif
   output logic        busy,
   output logic        done,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   output logic        s_ready,
   output logic        m_valid,
   output logic [7:0]  m_data,
   output logic        m_last,
   input  logic        m_ready
);

   localparam int FRAME = IMG_W * IMG_H;
   localparam int PCW   = (FRAME > 1) ? $clog2(FRAME) : 1;
   localparam int WCW   = (WARMUP > 1) ? $clog2(WARMUP) : 1;
   localparam logic [PCW-1:0] LAST_IDX = PCW'(FRAME - 1);
   localparam logic [WCW-1:0] WARM_END = WCW'(WARMUP - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, WARM = 2'd1, RUN = 2'd2, FLUSH = 2'd3} state_t;

   state_t         state, next_state;
   logic [15:0]    x, r_gain, x_next;
   logic [7:0]     c_prev, k, out_byte, chain_byte;
   logic [WCW-1:0] wcnt;
   logic [PCW-1:0] pcnt;
   logic           accept, drain, last_pix;
`ifdef DIFFUSION_DECRYPT_EN
   logic           decrypt;
`endif

   // Logistic step in fixed point; never returns 0 so the map cannot lock at the origin.
   function automatic logic [15:0] map_step(input logic [15:0] xv, input logic [15:0] rv);
      logic [31:0] t;
      logic [31:0] u;
      logic [15:0] t16;
      logic [15:0] nx;
      t   = 32'(xv) * (32'h0001_0000 - 32'(xv));
      t16 = 16'(t >> 16);
      u   = 32'(t16) * 32'(rv);
      if ((u >> 30) != 32'd0) begin
         nx = 16'hFFFF;
      end else begin
         nx = 16'(u >> 14);
      end
      if (nx == 16'h0000) begin
         nx = 16'h0001;
      end
      return nx;
   endfunction

   assign s_ready  = (state == RUN) & (~m_valid | m_ready);
   assign accept   = s_valid & s_ready;
   assign drain    = m_valid & m_ready;
   assign last_pix = (pcnt == LAST_IDX);

   // Keystream byte and substituted/chained pixel for the current input.
   always_comb begin
      k          = x[15:8];
      x_next     = map_step(x, r_gain);
      out_byte   = (s_data + k) ^ k ^ c_prev;
      chain_byte = out_byte;
`ifdef DIFFUSION_DECRYPT_EN
      if (decrypt) begin
         out_byte   = (s_data ^ k ^ c_prev) - k;
         chain_byte = s_data;
      end else begin
         out_byte   = (s_data + k) ^ k ^ c_prev;
         chain_byte = out_byte;
      end
`endif
   end

   // Frame sequencing.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = (WARMUP == 0) ? RUN : WARM;
            end else begin
               next_state = IDLE;
            end
         end
         WARM: begin
            if (wcnt == WARM_END) begin
               next_state = RUN;
            end else begin
               next_state = WARM;
            end
         end
         RUN: begin
            if (accept && last_pix) begin
               next_state = FLUSH;
            end else begin
               next_state = RUN;
            end
         end
         FLUSH: begin
            if (drain) begin
               next_state = IDLE;
            end else begin
               next_state = FLUSH;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Map state, chaining value, counters and the single output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         x       <= 16'h0000;
         r_gain  <= 16'h0000;
         c_prev  <= 8'h00;
         wcnt    <= '0;
         pcnt    <= '0;
         m_valid <= 1'b0;
         m_data  <= 8'h00;
         m_last  <= 1'b0;
         done    <= 1'b0;
         busy    <= 1'b0;
`ifdef DIFFUSION_DECRYPT_EN
         decrypt <= 1'b0;
`endif
      end else begin
         state <= next_state;
         done  <= (state == FLUSH) & drain;
         busy  <= (next_state != IDLE);
         if (state == IDLE && start) begin
            x      <= (cfg_seed == 16'h0000) ? 16'h0001 : cfg_seed;
            r_gain <= cfg_r;
            c_prev <= cfg_c0;
            wcnt   <= '0;
            pcnt   <= '0;
`ifdef DIFFUSION_DECRYPT_EN
            decrypt <= cfg_decrypt;
`endif
         end else if (state == WARM) begin
            x    <= x_next;
            wcnt <= wcnt + WCW'(1);
         end else if (accept) begin
            x      <= x_next;
            c_prev <= chain_byte;
            pcnt   <= pcnt + PCW'(1);
         end
         // Data holds while stalled; only valid/last clear on drain.
         if (accept) begin
            m_valid <= 1'b1;
            m_data  <= out_byte;
            m_last  <= last_pix;
         end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pixel_diffusion.sv
// Directed self-checking bench for pixel_diffusion on a reduced 8x4 frame.
// Define DIFFUSION_DECRYPT_EN to also exercise the decrypt round trip.
module tb_pixel_diffusion;

   localparam int W     = 8;
   localparam int H     = 4;
   localparam int WU    = 16;
   localparam int FRAME = W * H;

   logic        clk = 1'b0;
   logic        rst_n, start, s_valid, m_ready;
   logic [15:0] cfg_seed, cfg_r;
   logic [7:0]  cfg_c0, s_data;
   logic        busy, done, s_ready, m_valid, m_last;
   logic [7:0]  m_data;
   logic        cfg_decrypt;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] px     [FRAME];
   logic [7:0] exp_a  [FRAME];
   logic [7:0] orig   [FRAME];
   logic [7:0] out_q  [$];
   logic       last_q [$];
   logic [7:0] ref_q  [$];

   always #5 clk = ~clk;

   pixel_diffusion #(.IMG_W(W), .IMG_H(H), .WARMUP(WU)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_seed(cfg_seed), .cfg_r(cfg_r), .cfg_c0(cfg_c0),
`ifdef DIFFUSION_DECRYPT_EN
      .cfg_decrypt(cfg_decrypt),
`endif
      .busy(busy), .done(done),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [15:0] model_step(input logic [15:0] xv, input logic [15:0] rv);
      longint t, t16, u, nx;
      t   = longint'(xv) * (longint'(65536) - longint'(xv));
      t16 = t / 65536;
      u   = t16 * longint'(rv);
      if (u >= (longint'(1) << 30)) nx = 65535;
      else nx = (u / 16384) % 65536;
      if (nx == 0) nx = 1;
      return 16'(nx);
   endfunction

   task automatic build_expected(input logic [15:0] seed, input logic [15:0] rg,
                                 input logic [7:0] c0, input logic dec);
      logic [15:0] xv;
      logic [7:0]  kv, cp, c;
      xv = (seed == 16'h0000) ? 16'h0001 : seed;
      cp = c0;
      for (int i = 0; i < WU; i++) xv = model_step(xv, rg);
      for (int i = 0; i < FRAME; i++) begin
         kv = xv[15:8];
         if (dec) begin
            exp_a[i] = 8'((px[i] ^ kv ^ cp) - kv);
            cp = px[i];
         end else begin
            c = 8'(px[i] + kv) ^ kv ^ cp;
            exp_a[i] = c;
            cp = c;
         end
         xv = model_step(xv, rg);
      end
   endtask

   task automatic run_frame(input logic [15:0] seed, input logic [15:0] rg, input logic [7:0] c0,
                            input logic dec, input bit bp, input int abort_at, input bit poke);
      int in_idx, first_acc, first_out, last_out, done_it, stall_err, done_cnt, n_last;
      logic [7:0] held;
      logic busy_at_done;
      bit stalled, fin;
      out_q.delete();
      last_q.delete();
      in_idx = 0; first_acc = -1; first_out = -1; last_out = -1; done_it = -1;
      stall_err = 0; done_cnt = 0; stalled = 0; fin = 0; held = 8'h00; busy_at_done = 1'b1;
      cfg_seed = seed; cfg_r = rg; cfg_c0 = c0; cfg_decrypt = dec; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val("busy_after_start", 32'(busy), 32'd1);
      for (int it = 0; it < FRAME * 4 + 100 && !fin; it++) begin
         start = poke && (it == 3);
         if (poke && it == 3) begin
            cfg_c0 = ~c0;
            cfg_seed = seed ^ 16'h1234;
         end
         m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         s_valid = (in_idx < FRAME);
         s_data  = s_valid ? px[in_idx] : 8'h00;
         #1;
         if (stalled && (!m_valid || m_data !== held)) stall_err++;
         stalled = m_valid && !m_ready;
         held = m_data;
         if (done) begin
            done_cnt++;
            if (done_it < 0) begin
               done_it = it;
               busy_at_done = busy;
            end
         end
         if (s_valid && s_ready) begin
            if (first_acc < 0) first_acc = it;
            in_idx++;
         end
         if (m_valid && m_ready) begin
            out_q.push_back(m_data);
            last_q.push_back(m_last);
            if (first_out < 0) first_out = it;
            last_out = it;
         end
         if (abort_at >= 0 && in_idx == abort_at) begin
            rst_n = 1'b0;
            #1;
            check_val("abort_busy", 32'(busy), 32'd0);
            check_val("abort_mvalid", 32'(m_valid), 32'd0);
            check_val("abort_sready", 32'(s_ready), 32'd0);
            s_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            for (int j = 0; j < 30; j++) begin
               @(negedge clk);
               if (done) done_cnt++;
            end
            check_val("abort_no_done", 32'(done_cnt), 32'd0);
            return;
         end
         if (done_it >= 0 && it == done_it + 1) fin = 1;
         @(negedge clk);
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      check_val("frame_finished", 32'(fin), 32'd1);
      check_val("out_count", 32'(out_q.size()), 32'(FRAME));
      check_val("done_pulses", 32'(done_cnt), 32'd1);
      check_val("done_latency", 32'(done_it - last_out), 32'd1);
      check_val("busy_at_done", 32'(busy_at_done), 32'd0);
      check_val("first_accept", 32'(first_acc), 32'(WU));
      if (bp) check_val("stall_hold", 32'(stall_err), 32'd0);
      else check_val("no_bubbles", 32'(last_out - first_out + 1), 32'(FRAME));
      n_last = 0;
      foreach (last_q[i]) if (last_q[i]) n_last++;
      check_val("last_count", 32'(n_last), 32'd1);
      if (last_q.size() == FRAME) check_val("last_pos", 32'(last_q[FRAME-1]), 32'd1);
      build_expected(seed, rg, c0, dec);
      for (int i = 0; i < out_q.size() && i < FRAME; i++)
         check_val($sformatf("px%0d", i), 32'(out_q[i]), 32'(exp_a[i]));
   endtask

   initial begin
      int diffs;
      rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; m_ready = 1'b1; s_data = 8'h00;
      cfg_seed = 16'h0000; cfg_r = 16'h0000; cfg_c0 = 8'h00; cfg_decrypt = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_mvalid", 32'(m_valid), 32'd0);
      check_val("rst_mdata", 32'(m_data), 32'd0);
      check_val("rst_mlast", 32'(m_last), 32'd0);
      check_val("rst_sready", 32'(s_ready), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // x fixed at 0x8000 -> k=0x80; inputs 10,20 give 10,30
      foreach (px[i]) px[i] = 8'($urandom);
      px[0] = 8'd10;
      px[1] = 8'd20;
      run_frame(16'h8000, 16'h8000, 8'h00, 1'b0, 1'b0, -1, 1'b0);
      if (out_q.size() >= 2) begin
         check_val("fixed_out0", 32'(out_q[0]), 32'd10);
         check_val("fixed_out1", 32'(out_q[1]), 32'd30);
      end

      foreach (px[i]) px[i] = 8'($urandom);
      run_frame(16'h1234, 16'hF000, 8'h5A, 1'b0, 1'b0, -1, 1'b0);
      ref_q = out_q;
      run_frame(16'h1234, 16'hF000, 8'h5A, 1'b0, 1'b1, -1, 1'b1);
      diffs = 0;
      if (out_q.size() != ref_q.size()) diffs++;
      else foreach (out_q[i]) if (out_q[i] !== ref_q[i]) diffs++;
      check_val("bp_vs_ref", 32'(diffs), 32'd0);

      run_frame(16'h0000, 16'hE000, 8'h33, 1'b0, 1'b0, -1, 1'b0);
      run_frame(16'h8000, 16'hFFFF, 8'hA5, 1'b0, 1'b0, -1, 1'b0);

      foreach (px[i]) px[i] = 8'($urandom);
      run_frame(16'h4321, 16'hE800, 8'h77, 1'b0, 1'b0, 10, 1'b0);
      run_frame(16'h4321, 16'hE800, 8'h77, 1'b0, 1'b1, -1, 1'b0);

`ifdef DIFFUSION_DECRYPT_EN
      foreach (px[i]) begin
         px[i] = 8'($urandom);
         orig[i] = px[i];
      end
      run_frame(16'h2468, 16'hF800, 8'hC3, 1'b0, 1'b0, -1, 1'b0);
      for (int i = 0; i < out_q.size() && i < FRAME; i++) px[i] = out_q[i];
      run_frame(16'h2468, 16'hF800, 8'hC3, 1'b1, 1'b1, -1, 1'b0);
      diffs = 0;
      if (out_q.size() != FRAME) diffs++;
      else foreach (out_q[i]) if (out_q[i] !== orig[i]) diffs++;
      check_val("decrypt_roundtrip", 32'(diffs), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
